// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - E-stage request/response bundle for the M-extension unit
interface muldiv_unit_if #(parameter int DATA_WIDTH = 32);
  logic                  startE;
  logic                  flushE;
  logic [2:0]            funct3E;
  logic [DATA_WIDTH-1:0] srcAE;
  logic [DATA_WIDTH-1:0] srcBE;
  logic                  stallE;
  logic                  doneE;
  logic [DATA_WIDTH-1:0] resultE;

  modport master (
    output startE, flushE, funct3E, srcAE, srcBE,
    input  stallE, doneE, resultE
  );

  modport slave (
    input  startE, flushE, funct3E, srcAE, srcBE,
    output stallE, doneE, resultE
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide, one bit per cycle
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  muldiv_unit_if.slave   bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [W-1:0] MIN_INT = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state;
  logic [CW-1:0]  count;
  logic [2:0]     op;
  logic           neg;
  logic [W-1:0]   mag_op;
  logic [2*W-1:0] acc;
  logic           done_q;
  logic [W-1:0]   result_q;

  logic           a_signed, b_signed, sign_a, sign_b, neg_in;
  logic [W-1:0]   mag_a, mag_b;
  logic           div_zero, div_ovf;
  logic [W-1:0]   fast_result;
  logic [W:0]     mul_sum;
  logic [W:0]     div_shift;
  logic           div_ge;
  logic [W-1:0]   div_rem;
  logic [2*W-1:0] acc_next;
  logic [2*W-1:0] prod;
  logic [W-1:0]   div_val;
  logic [W-1:0]   final_result;

  always_comb begin
    a_signed    = (bus.funct3E != 3'b011) && (bus.funct3E != 3'b101) && (bus.funct3E != 3'b111);
    b_signed    = (bus.funct3E == 3'b000) || (bus.funct3E == 3'b001) ||
                  (bus.funct3E == 3'b100) || (bus.funct3E == 3'b110);
    sign_a      = a_signed & bus.srcAE[W-1];
    sign_b      = b_signed & bus.srcBE[W-1];
    mag_a       = sign_a ? -bus.srcAE : bus.srcAE;
    mag_b       = sign_b ? -bus.srcBE : bus.srcBE;
    // REM/REMU follow the dividend sign; everything else follows the product/quotient sign
    neg_in      = (bus.funct3E[2] & bus.funct3E[1]) ? sign_a : (sign_a ^ sign_b);
    div_zero    = bus.funct3E[2] & (bus.srcBE == '0);
    div_ovf     = bus.funct3E[2] & ~bus.funct3E[0] &
                  (bus.srcAE == MIN_INT) & (bus.srcBE == '1);
    fast_result = div_zero ? (bus.funct3E[1] ? bus.srcAE : '1)
                           : (bus.funct3E[1] ? '0 : MIN_INT);
  end

  // One shift-add (multiply) or restore-subtract (divide) step on acc
  always_comb begin
    mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mag_op} : '0);
    div_shift = acc[2*W-1:W-1];
    div_ge    = div_shift >= {1'b0, mag_op};
    div_rem   = div_ge ? (div_shift[W-1:0] - mag_op) : div_shift[W-1:0];
    if (op[2]) acc_next = {div_rem, acc[W-2:0], div_ge};
    else       acc_next = {mul_sum, acc[W-1:1]};
    prod    = neg ? -acc_next : acc_next;
    div_val = op[1] ? acc_next[2*W-1:W] : acc_next[W-1:0];
    if (op[2])              final_result = neg ? -div_val : div_val;
    else if (op == 3'b000)  final_result = prod[W-1:0];
    else                    final_result = prod[2*W-1:W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      op       <= '0;
      neg      <= 1'b0;
      mag_op   <= '0;
      acc      <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.flushE) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (bus.startE) begin
              op    <= bus.funct3E;
              neg   <= neg_in;
              count <= CW'(W-1);
              if (div_zero || div_ovf) begin
                result_q <= fast_result;
                done_q   <= 1'b1;
                state    <= DONE;
              end else begin
                mag_op <= bus.funct3E[2] ? mag_b : mag_a;
                acc    <= bus.funct3E[2] ? {{W{1'b0}}, mag_a} : {{W{1'b0}}, mag_b};
                state  <= CALC;
              end
            end
          end
          CALC: begin
            acc   <= acc_next;
            count <= count - 1'b1;
            if (count == '0) begin
              result_q <= final_result;
              done_q   <= 1'b1;
              state    <= DONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.stallE  = ((state == IDLE) & bus.startE & ~bus.flushE) | (state == CALC);
  assign bus.doneE   = done_q;
  assign bus.resultE = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_result = 32'h0;

  muldiv_unit_if #(.DATA_WIDTH(32)) bus ();
  muldiv_unit #(.DATA_WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f3)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * longint'({32'h0, b}); return p[63:32]; end
      3'b011: begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'b101: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input string name);
    int stalls = 0;
    int cycles = 0;
    int exp_stall;
    bit got = 0;
    logic [31:0] exp;
    exp_stall = (f3[2] && (b == 0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) ? 1 : 33;
    sb_q.push_back(model(f3, a, b));
    bus.startE = 1'b1; bus.funct3E = f3; bus.srcAE = a; bus.srcBE = b;
    while (!got && cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (bus.stallE) stalls++;
      if (bus.doneE) begin
        got = 1;
        exp = sb_q.pop_front();
        last_result = exp;
        total++;
        if (bus.resultE !== exp) begin
          bad++; $display("FAIL %s result got=%h exp=%h", name, bus.resultE, exp);
        end
        total++;
        if (stalls !== exp_stall) begin
          bad++; $display("FAIL %s stall_cycles got=%0d exp=%0d", name, stalls, exp_stall);
        end
      end
      @(posedge clk); #1;
      // operands change after the issuing edge must be ignored
      bus.srcAE = $urandom; bus.srcBE = $urandom;
    end
    bus.startE = 1'b0;
    if (!got) begin
      total++; bad++;
      void'(sb_q.pop_front());
      $display("FAIL %s timeout waiting for doneE", name);
    end
  endtask

  task automatic test_reset;
    bus.startE = 0; bus.flushE = 0; bus.funct3E = 0; bus.srcAE = 0; bus.srcBE = 0;
    #2;
    total++;
    if (bus.stallE !== 1'b0 || bus.doneE !== 1'b0 || bus.resultE !== 32'h0) begin
      bad++; $display("FAIL reset_state got stall=%b done=%b result=%h exp 0/0/0", bus.stallE, bus.doneE, bus.resultE);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul;
    run_op(3'b000, 32'd7, 32'hFFFFFFFD, "mul_7_m3");
    run_op(3'b000, 32'h12345678, 32'h9ABCDEF0, "mul_rand");
  endtask

  task automatic test_mulh;
    run_op(3'b001, 32'h80000000, 32'h80000000, "mulh_min");
    run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhu_max");
    run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu_max");
    run_op(3'b001, 32'hFFFFFFF0, 32'h00012345, "mulh_negpos");
  endtask

  task automatic test_div;
    run_op(3'b100, 32'hFFFFFFF9, 32'd2, "div_m7_2");
    run_op(3'b110, 32'hFFFFFFF9, 32'd2, "rem_m7_2");
    run_op(3'b101, 32'd100, 32'd7, "divu_100_7");
    run_op(3'b111, 32'd100, 32'd7, "remu_100_7");
    run_op(3'b110, 32'd7, 32'hFFFFFFFE, "rem_7_m2");
    run_op(3'b101, 32'hFFFFFFFF, 32'd1, "divu_max_1");
  endtask

  task automatic test_fast;
    run_op(3'b101, 32'd5, 32'd0, "divu_by_zero");
    run_op(3'b110, 32'd5, 32'd0, "rem_by_zero");
    run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, "div_overflow");
    run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, "rem_overflow");
  endtask

  task automatic test_flush;
    bit seen = 0;
    bus.startE = 1; bus.funct3E = 3'b100; bus.srcAE = 32'd1000; bus.srcBE = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    bus.startE = 0; bus.flushE = 1;
    @(posedge clk); #1;
    bus.flushE = 0;
    @(negedge clk);
    total++;
    if (bus.stallE !== 1'b0 || bus.doneE !== 1'b0) begin
      bad++; $display("FAIL flush_idle got stall=%b done=%b exp 0/0", bus.stallE, bus.doneE);
    end
    repeat (40) begin @(negedge clk); if (bus.doneE) seen = 1; end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL flush_no_done got=1 exp=0"); end
    total++;
    if (bus.resultE !== last_result) begin
      bad++; $display("FAIL flush_result got=%h exp=%h", bus.resultE, last_result);
    end
  endtask

  task automatic test_async_reset;
    bus.startE = 1; bus.funct3E = 3'b000; bus.srcAE = 32'd9; bus.srcBE = 32'd9;
    repeat (6) @(posedge clk);
    #2;
    bus.startE = 0; rst_n = 0;
    #1;
    total++;
    if (bus.stallE !== 1'b0 || bus.doneE !== 1'b0 || bus.resultE !== 32'h0) begin
      bad++; $display("FAIL async_reset got stall=%b done=%b result=%h exp 0/0/0", bus.stallE, bus.doneE, bus.resultE);
    end
    last_result = 32'h0;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    bit seen = 0;
    run_op(3'b000, 32'd11, 32'd13, "b2b_first");
    run_op(3'b101, 32'd1000, 32'd9, "b2b_second");
    @(negedge clk);
    total++;
    if (bus.doneE !== 1'b0 || bus.stallE !== 1'b0) begin
      bad++; $display("FAIL done_pulse_width got done=%b stall=%b exp 0/0", bus.doneE, bus.stallE);
    end
    repeat (40) begin @(negedge clk); if (bus.doneE || bus.stallE) seen = 1; end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL no_restart got=1 exp=0"); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_fast();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
